// File: rtl/arm_decode_pipe.sv
// ARM-subset instruction decoder with the ID/EX and EX/MEM control pipeline registers.
// The decoder is combinational. The two register stages each have a synchronous, active-low reset and a load enable.
module arm_decode_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_id_ex,
    input  logic        enable_ex_mem,
    input  logic        nop_sel,
    input  logic [31:0] instruction,
    input  logic [31:0] id_pc,
    output logic [3:0]  ID_ALU_op,
    output logic [1:0]  ID_SHIFT_am,
    output logic        ID_load_instr,
    output logic        ID_RF_enable,
    output logic        ID_DM_size,
    output logic        ID_DM_rfw,
    output logic        ID_DM_enable,
    output logic        ID_DP_instr,
    output logic        ID_B_instr,
    output logic        ID_BL_instr,
    output logic [3:0]  EX_ALU_op,
    output logic [1:0]  EX_SHIFT_am,
    output logic        EX_load_instr,
    output logic        EX_RF_enable,
    output logic        EX_DM_size,
    output logic        EX_DM_rfw,
    output logic        EX_DM_enable,
    output logic        EX_DP_instr,
    output logic [31:0] ex_pc,
    output logic        MEM_load_instr,
    output logic        MEM_RF_enable,
    output logic        MEM_DM_size,
    output logic        MEM_DM_rfw,
    output logic        MEM_DM_enable,
    output logic [31:0] mem_pc
);

    logic [2:0] instr_class;
    logic [3:0] opcode;

    assign instr_class = instruction[27:25];
    assign opcode      = instruction[24:21];

    always_comb begin
        ID_ALU_op     = 4'b0000;
        ID_SHIFT_am   = 2'b00;
        ID_load_instr = 1'b0;
        ID_RF_enable  = 1'b0;
        ID_DM_size    = 1'b0;
        ID_DM_rfw     = 1'b0;
        ID_DM_enable  = 1'b0;
        ID_DP_instr   = 1'b0;
        ID_B_instr    = 1'b0;
        ID_BL_instr   = 1'b0;
        if (instruction != 32'h0000_0000) begin
            case (instr_class)
                3'b000, 3'b001: begin
                    // Class 000 with [7:4]=1001 is multiply/swap space, which is not supported.
                    if (!(instr_class == 3'b000 && instruction[7:4] == 4'b1001)) begin
                        ID_DP_instr  = 1'b1;
                        ID_ALU_op    = opcode;
                        ID_SHIFT_am  = (instr_class == 3'b000) ? 2'b01 : 2'b00;
                        // TST/TEQ/CMP/CMN only set flags and write no register.
                        ID_RF_enable = (opcode[3:2] != 2'b10);
                    end
                end
                3'b010, 3'b011: begin
                    ID_DM_enable  = 1'b1;
                    ID_ALU_op     = instruction[23] ? 4'b0100 : 4'b0010;
                    ID_SHIFT_am   = (instr_class == 3'b010) ? 2'b10 : 2'b11;
                    ID_DM_size    = instruction[22];
                    ID_load_instr = instruction[20];
                    ID_RF_enable  = instruction[20];
                    ID_DM_rfw     = ~instruction[20];
                end
                3'b101: begin
                    ID_B_instr   = 1'b1;
                    ID_BL_instr  = instruction[24];
                    ID_RF_enable = instruction[24];
                    ID_ALU_op    = 4'b0100;
                end
                default: begin
                end
            endcase
        end
    end

    // Bubble mux: the ID outputs are left intact, and only the copy headed into ID/EX is squashed.
    logic [3:0] mux_alu_op;
    logic [1:0] mux_shift_am;
    logic       mux_load, mux_rf_en, mux_dm_size, mux_dm_rfw, mux_dm_en, mux_dp;

    always_comb begin
        mux_alu_op   = ID_ALU_op;
        mux_shift_am = ID_SHIFT_am;
        mux_load     = ID_load_instr;
        mux_rf_en    = ID_RF_enable;
        mux_dm_size  = ID_DM_size;
        mux_dm_rfw   = ID_DM_rfw;
        mux_dm_en    = ID_DM_enable;
        mux_dp       = ID_DP_instr;
        if (nop_sel) begin
            mux_alu_op   = 4'b0000;
            mux_shift_am = 2'b00;
            mux_load     = 1'b0;
            mux_rf_en    = 1'b0;
            mux_dm_size  = 1'b0;
            mux_dm_rfw   = 1'b0;
            mux_dm_en    = 1'b0;
            mux_dp       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            EX_ALU_op     <= 4'b0000;
            EX_SHIFT_am   <= 2'b00;
            EX_load_instr <= 1'b0;
            EX_RF_enable  <= 1'b0;
            EX_DM_size    <= 1'b0;
            EX_DM_rfw     <= 1'b0;
            EX_DM_enable  <= 1'b0;
            EX_DP_instr   <= 1'b0;
            ex_pc         <= 32'h0000_0000;
        end else if (enable_id_ex) begin
            EX_ALU_op     <= mux_alu_op;
            EX_SHIFT_am   <= mux_shift_am;
            EX_load_instr <= mux_load;
            EX_RF_enable  <= mux_rf_en;
            EX_DM_size    <= mux_dm_size;
            EX_DM_rfw     <= mux_dm_rfw;
            EX_DM_enable  <= mux_dm_en;
            EX_DP_instr   <= mux_dp;
            ex_pc         <= id_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            MEM_load_instr <= 1'b0;
            MEM_RF_enable  <= 1'b0;
            MEM_DM_size    <= 1'b0;
            MEM_DM_rfw     <= 1'b0;
            MEM_DM_enable  <= 1'b0;
            mem_pc         <= 32'h0000_0000;
        end else if (enable_ex_mem) begin
            MEM_load_instr <= EX_load_instr;
            MEM_RF_enable  <= EX_RF_enable;
            MEM_DM_size    <= EX_DM_size;
            MEM_DM_rfw     <= EX_DM_rfw;
            MEM_DM_enable  <= EX_DM_enable;
            mem_pc         <= ex_pc;
        end
    end

endmodule

// File: tb/tb_arm_decode_pipe.sv
// Bench for arm_decode_pipe: directed test-plan steps followed by randomized instructions.
// Each cycle is checked against a reference decoder and a stage model.
module tb_arm_decode_pipe;

    logic        clk;
    logic        reset;
    logic        enable_id_ex;
    logic        enable_ex_mem;
    logic        nop_sel;
    logic [31:0] instruction;
    logic [31:0] id_pc;
    logic [3:0]  ID_ALU_op, EX_ALU_op;
    logic [1:0]  ID_SHIFT_am, EX_SHIFT_am;
    logic        ID_load_instr, ID_RF_enable, ID_DM_size, ID_DM_rfw, ID_DM_enable;
    logic        ID_DP_instr, ID_B_instr, ID_BL_instr;
    logic        EX_load_instr, EX_RF_enable, EX_DM_size, EX_DM_rfw, EX_DM_enable, EX_DP_instr;
    logic        MEM_load_instr, MEM_RF_enable, MEM_DM_size, MEM_DM_rfw, MEM_DM_enable;
    logic [31:0] ex_pc, mem_pc;

    int checks = 0;
    int errors = 0;

    arm_decode_pipe dut (
        .clk(clk), .reset(reset), .enable_id_ex(enable_id_ex), .enable_ex_mem(enable_ex_mem),
        .nop_sel(nop_sel), .instruction(instruction), .id_pc(id_pc),
        .ID_ALU_op(ID_ALU_op), .ID_SHIFT_am(ID_SHIFT_am), .ID_load_instr(ID_load_instr),
        .ID_RF_enable(ID_RF_enable), .ID_DM_size(ID_DM_size), .ID_DM_rfw(ID_DM_rfw),
        .ID_DM_enable(ID_DM_enable), .ID_DP_instr(ID_DP_instr), .ID_B_instr(ID_B_instr),
        .ID_BL_instr(ID_BL_instr),
        .EX_ALU_op(EX_ALU_op), .EX_SHIFT_am(EX_SHIFT_am), .EX_load_instr(EX_load_instr),
        .EX_RF_enable(EX_RF_enable), .EX_DM_size(EX_DM_size), .EX_DM_rfw(EX_DM_rfw),
        .EX_DM_enable(EX_DM_enable), .EX_DP_instr(EX_DP_instr), .ex_pc(ex_pc),
        .MEM_load_instr(MEM_load_instr), .MEM_RF_enable(MEM_RF_enable), .MEM_DM_size(MEM_DM_size),
        .MEM_DM_rfw(MEM_DM_rfw), .MEM_DM_enable(MEM_DM_enable), .mem_pc(mem_pc)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit layout of a decoded word: {alu[3:0], shift[1:0], load, rf_en, size, rfw, dm_en, dp, b, bl}
    typedef struct {
        logic [3:0] alu;
        logic [1:0] shift;
        logic load, rf, size, rfw, dme, dp, b, bl;
    } ctl_t;

    // Stage model: control and PC values expected in the EX and MEM registers.
    ctl_t        m_ex, m_mem;
    logic [31:0] m_ex_pc, m_mem_pc;

    function automatic ctl_t zero_ctl();
        ctl_t c;
        c.alu = 4'd0; c.shift = 2'd0;
        c.load = 0; c.rf = 0; c.size = 0; c.rfw = 0; c.dme = 0; c.dp = 0; c.b = 0; c.bl = 0;
        return c;
    endfunction

    // Reference decoder, written from the instruction-class rules.
    function automatic ctl_t ref_decode(input logic [31:0] ins);
        ctl_t c;
        int   cls, op;
        bit   is_mul, is_test;
        c = zero_ctl();
        cls     = int'(ins[27:25]);
        op      = int'(ins[24:21]);
        is_mul  = (ins[7:4] == 4'b1001);
        is_test = (op >= 8 && op <= 11);
        if (ins == 0) return c;
        if ((cls == 0 && !is_mul) || cls == 1) begin
            c.dp = 1; c.alu = ins[24:21]; c.rf = !is_test;
            c.shift = (cls == 0) ? 2'd1 : 2'd0;
        end else if (cls == 2 || cls == 3) begin
            c.dme = 1;
            c.alu = ins[23] ? 4'd4 : 4'd2;
            c.shift = (cls == 2) ? 2'd2 : 2'd3;
            c.size = ins[22]; c.load = ins[20]; c.rf = ins[20]; c.rfw = !ins[20];
        end else if (cls == 5) begin
            c.b = 1; c.bl = ins[24]; c.rf = ins[24]; c.alu = 4'd4;
        end
        return c;
    endfunction

    function automatic logic [13:0] pack_id(input ctl_t c);
        return {c.alu, c.shift, c.load, c.rf, c.size, c.rfw, c.dme, c.dp, c.b, c.bl};
    endfunction

    function automatic logic [11:0] pack_ex(input ctl_t c);
        return {c.alu, c.shift, c.load, c.rf, c.size, c.rfw, c.dme, c.dp};
    endfunction

    function automatic logic [4:0] pack_mem(input ctl_t c);
        return {c.load, c.rf, c.size, c.rfw, c.dme};
    endfunction

    // Scoreboard compare
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] dut_id();
        return {ID_ALU_op, ID_SHIFT_am, ID_load_instr, ID_RF_enable, ID_DM_size, ID_DM_rfw,
                ID_DM_enable, ID_DP_instr, ID_B_instr, ID_BL_instr};
    endfunction

    function automatic logic [11:0] dut_ex();
        return {EX_ALU_op, EX_SHIFT_am, EX_load_instr, EX_RF_enable, EX_DM_size, EX_DM_rfw,
                EX_DM_enable, EX_DP_instr};
    endfunction

    function automatic logic [4:0] dut_mem();
        return {MEM_load_instr, MEM_RF_enable, MEM_DM_size, MEM_DM_rfw, MEM_DM_enable};
    endfunction

    // Driver: apply one cycle of inputs, check ID, advance the model across the edge, then check EX/MEM.
    task automatic step(input logic rst_n, input logic en1, input logic en2, input logic nop,
                        input logic [31:0] ins, input logic [31:0] pc);
        ctl_t d;
        reset = rst_n; enable_id_ex = en1; enable_ex_mem = en2; nop_sel = nop;
        instruction = ins; id_pc = pc;
        #1;
        d = ref_decode(ins);
        chk("id_decode", 64'(dut_id()), 64'(pack_id(d)));
        if (!rst_n) begin
            m_ex = zero_ctl(); m_ex_pc = 0; m_mem = zero_ctl(); m_mem_pc = 0;
        end else begin
            if (en2) begin
                m_mem = m_ex; m_mem_pc = m_ex_pc;
            end
            if (en1) begin
                m_ex = nop ? zero_ctl() : d; m_ex_pc = pc;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_ctl", 64'(dut_ex()), 64'(pack_ex(m_ex)));
        chk("ex_pc", 64'(ex_pc), 64'(m_ex_pc));
        chk("mem_ctl", 64'(dut_mem()), 64'(pack_mem(m_mem)));
        chk("mem_pc", 64'(mem_pc), 64'(m_mem_pc));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ex_pc_hold;
        reset = 1'b1; enable_id_ex = 1'b0; enable_ex_mem = 1'b0; nop_sel = 1'b0;
        instruction = 32'h0; id_pc = 32'h0;
        m_ex = zero_ctl(); m_mem = zero_ctl(); m_ex_pc = 0; m_mem_pc = 0;
        @(posedge clk);
        #1;

        // Reset with enables high; ID still decodes the ADDS.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hE0910002, 32'h10);
        chk("reset_ex_pc", 64'(ex_pc), 64'h0);
        chk("reset_mem_ctl", 64'(dut_mem()), 64'h0);

        // ADDS r0,r1,r2 flows through both stages.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE0910002, 32'h10);
        chk("adds_ex", 64'(dut_ex()), 64'({4'b0100, 2'b01, 6'b010001}));
        chk("adds_ex_pc", 64'(ex_pc), 64'h10);
        instruction = 32'hE5D21004; #1;
        chk("ldrb_id", 64'(dut_id()), 64'({4'b0100, 2'b10, 8'b11101000}));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE5D21004, 32'h14);
        chk("adds_mem_rf", 64'(MEM_RF_enable), 64'h1);
        chk("adds_mem_pc", 64'(mem_pc), 64'h10);
        instruction = 32'hE5021004; #1;
        chk("str_id", 64'(dut_id()), 64'({4'b0010, 2'b10, 8'b00011000}));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE5021004, 32'h18);
        chk("ldrb_mem", 64'(dut_mem()), 64'(5'b11101));
        instruction = 32'hE3510005; #1;
        chk("cmp_id", 64'(dut_id()), 64'({4'b1010, 2'b00, 8'b00000100}));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE3510005, 32'h1C);
        chk("str_mem", 64'(dut_mem()), 64'(5'b00011));
        instruction = 32'hEB000002; #1;
        chk("bl_id", 64'(dut_id()), 64'({4'b0100, 2'b00, 8'b01000011}));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hEB000002, 32'h20);
        instruction = 32'hEA000002; #1;
        chk("b_id", 64'(dut_id()), 64'({4'b0100, 2'b00, 8'b00000010}));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hEA000002, 32'h24);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h28);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE0000091, 32'h2C);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE8000000, 32'h30);

        // Bubble with LDRB in ID.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hE5D21004, 32'h34);
        chk("bubble_ex", 64'(dut_ex()), 64'h0);

        // Stall ID/EX for two edges while the instruction changes.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE5D21004, 32'h38);
        ex_pc_hold = ex_pc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'hE0910002, 32'h3C);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'hE3510005, 32'h40);
        chk("stall_ex_pc", 64'(ex_pc), 64'(32'h38));
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hE5021004, 32'h44);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hEB000002, 32'h48);
        chk("hold_mem_pc", 64'(mem_pc), 64'(ex_pc_hold));
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'hE0910002, 32'h4C);
        chk("reset_idle_ex", 64'({dut_ex(), ex_pc}), 64'h0);

        // Randomized stimulus across all instruction classes, enables, bubbles and resets.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0: r = 32'h0;
                1: begin r[27:25] = 3'b000; r[7:4] = 4'b1001; end
                2: r[27:25] = 3'b000;
                3: r[27:25] = 3'b001;
                4: r[27:25] = 3'b010;
                5: r[27:25] = 3'b011;
                6: r[27:25] = 3'b101;
                7: r[27:25] = 3'b100;
                8: r[27:25] = 3'(6 + $urandom_range(0, 1));
                default: ;
            endcase
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), r, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_decode_pipe.md
Name: arm_decode_pipe

Overview:
- ARM-subset instruction decoder plus the ID/EX and EX/MEM control pipeline registers of the 5-stage core.
- Decodes the IF/ID instruction into combinational ID-stage control signals.
- Optionally squashes the decoded signals to a bubble, then carries them and the PC through EX and MEM.
- Condition-code evaluation, hazard detection and the datapath live outside this block.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- enable_id_ex  in  1  load enable for the ID/EX register
- enable_ex_mem  in  1  load enable for the EX/MEM register
- nop_sel  in  1  1 = inject bubble (all-zero control) into ID/EX
- instruction  in  32  instruction from IF/ID
- id_pc  in  32  PC from IF/ID
- ID_ALU_op, ID_SHIFT_am  out  4, 2  decoded ALU operation / shifter mode
- ID_load_instr, ID_RF_enable, ID_DM_size, ID_DM_rfw, ID_DM_enable, ID_DP_instr, ID_B_instr, ID_BL_instr  out  1 each  decoded control
- EX_ALU_op, EX_SHIFT_am  out  4, 2  registered
- EX_load_instr, EX_RF_enable, EX_DM_size, EX_DM_rfw, EX_DM_enable, EX_DP_instr  out  1 each  registered
- ex_pc  out  32  registered PC
- MEM_load_instr, MEM_RF_enable, MEM_DM_size, MEM_DM_rfw, MEM_DM_enable  out  1 each  registered
- mem_pc  out  32  registered PC

Behaviour:
- Decoder is purely combinational. It ignores cond[31:28] and classifies on instruction[27:25].
- instruction == 0 → all ID outputs 0 (NOP).
- Class 000, data processing, immediate/register shift:
  - DP_instr=1, ALU_op=[24:21], SHIFT_am=01.
  - RF_enable=1 unless opcode is 1000–1011 (TST/TEQ/CMP/CMN).
  - Class 000 with [7:4]=1001 (multiply/swap) is unsupported and decodes to all 0.
- Class 001, data processing, rotated immediate: same as class 000 but SHIFT_am=00.
- Class 010, load/store, 12-bit immediate offset: SHIFT_am=10.
- Class 011, load/store, register offset: SHIFT_am=11.
- Both load/store classes:
  - DM_enable=1.
  - ALU_op=0100 (ADD) if U[23]=1, else 0010 (SUB).
  - DM_size=B[22] (1=byte, 0=word).
  - load_instr=L[20]; RF_enable=L[20].
  - DM_rfw=~L[20] (1=write/store).
  - DP_instr=0.
- Class 101, branch:
  - B_instr=1, BL_instr=L[24], RF_enable=L[24] (link write to R14).
  - ALU_op=0100, SHIFT_am=00.
  - All memory signals 0.
- Every other class (100, 11x) decodes to all 0.
- Any ID output not set by the class rules above is 0.
- Bubble mux: nop_sel=1 forces ALU_op, SHIFT_am, load, RF_enable, DM_size, DM_rfw, DM_enable and DP_instr into ID/EX as 0. ID_* outputs themselves are never squashed.
- B_instr/BL_instr are not pipelined.
- ID/EX register, on rising edge:
  - reset=0 → all EX_* and ex_pc = 0.
  - else if enable_id_ex=1 → capture mux outputs and id_pc.
  - else hold.
- EX/MEM register, on rising edge:
  - reset=0 → all MEM_* and mem_pc = 0.
  - else if enable_ex_mem=1 → capture EX_load_instr, EX_RF_enable, EX_DM_size, EX_DM_rfw, EX_DM_enable and ex_pc.
  - else hold.
  - ALU_op, SHIFT_am and DP_instr stop at EX.
- Latency: ID → EX is 1 cycle; ID → MEM is 2 cycles.
- Reset has priority over enable. Reset asserted mid-stream clears both stages on that edge with no partial state.
- Enables are independent. Holding ID/EX while EX/MEM is enabled re-copies the same EX values into MEM.

Test Plan:
- Reset: reset=0 for one edge with enables=1 and instruction=E0910002 → all EX_*/MEM_*/ex_pc/mem_pc = 0. ID_* still shows the ADDS decode.
- ADDS r0,r1,r2 (E0910002), id_pc=0x10:
  - ID: ALU 0100, SHIFT 01, DP 1, RF_E 1, rest 0.
  - Next edge: EX matches, ex_pc=0x10.
  - Edge after: MEM_RF_E=1, mem_pc=0x10.
- Memory ops:
  - LDRB r1,[r2,#4] (E5D21004) → ALU 0100, SHIFT 10, load 1, RF_E 1, size 1, rfw 0, DM_E 1.
  - STR r1,[r2,#-4] (E5021004) → ALU 0010, load 0, RF_E 0, size 0, rfw 1, DM_E 1.
  - Both appear in MEM after 2 edges.
- Compare and branches:
  - CMP r1,#5 (E3510005) → ALU 1010, SHIFT 00, DP 1, RF_E 0.
  - BL (EB000002) → B 1, BL 1, RF_E 1.
  - B (EA000002) → B 1, BL 0, RF_E 0.
- Bubble: nop_sel=1 with LDRB in ID → ID_* still shows the LDRB decode; EX_* all 0 after the edge.
- Stall: enable_id_ex=0 for 2 edges → EX_* and ex_pc hold while instruction changes. Then enable_ex_mem=0 → MEM_* hold. Then reset=0 with both enables=0 → all registers clear.
